// File: rtl/y_trim_if.sv
// AXI4-Stream video beat bundle shared by the y_trim input and output ports.
// Clock and reset are kept outside the bundle.
interface y_trim_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 4
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, tuser, tlast, tdata, input tready);
    modport slave  (input tvalid, tuser, tlast, tdata, output tready);
endinterface

// File: rtl/y_trim.sv
// Vertical ROI crop and line subsampler: keeps a window of lines, one of every
// y_scale+1 inside it, and rewrites SOF/SOL/EOL/EOF so the output frame is well-formed.
module y_trim #(
    parameter int LINE_CNT_W = 13
) (
    input  logic                  aclk,
    input  logic                  aclk_reset_n,
    input  logic                  aclk_y_crop_en,
    input  logic [LINE_CNT_W-1:0] aclk_y_start,
    input  logic [LINE_CNT_W-1:0] aclk_y_size,
    input  logic [3:0]            aclk_y_scale,
    y_trim_if.slave               aclk_s,
    y_trim_if.master              aclk_m,
    output logic                  aclk_frame_err
);
    localparam int LW = LINE_CNT_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_KEEP = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [3:0] U_SOF = 4'b0001;
    localparam logic [3:0] U_EOF = 4'b0010;
    localparam logic [3:0] U_SOL = 4'b0100;
    localparam logic [3:0] U_EOL = 4'b1000;

    // Frame state and config latched at SOF
    logic [1:0]    state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [3:0]    sub_q, sub_d;
    logic          first_q, first_d;
    logic          fk_q, fk_d;
    logic          crop_q, crop_d;
    logic [LW-1:0] start_q, start_d;
    logic [LW:0]   last_q, last_d;
    logic [3:0]    scale_q, scale_d;
    logic          err_q, err_d;
    logic          rdy_q;

    // Hold buffer and output buffer
    logic          hb_vld_q, hb_vld_d;
    logic [63:0]   hb_data_q, hb_data_d;
    logic [3:0]    hb_user_q, hb_user_d;
    logic          ob_vld_q;
    logic [63:0]   ob_data_q;
    logic [3:0]    ob_user_q;
    logic          ob_last_q;
    logic          ob_load;
    logic [63:0]   ob_data_n;
    logic [3:0]    ob_user_n;
    logic          ob_last_n;
    logic          ob_free;

    logic          s_tready, acc, rdy;
    logic [3:0]    beat_user;

    // last_kept for the config presented on the SOF beat
    logic [4:0]    scl_p1;
    logic [LW-1:0] sz_m1, quo, span;
    logic [LW:0]   last_in;

    assign scl_p1  = {1'b0, aclk_y_scale} + 5'd1;
    assign sz_m1   = aclk_y_size - LW'(1);
    assign quo     = sz_m1 / LW'(scl_p1);
    assign span    = quo * LW'(scl_p1);
    assign last_in = {1'b0, aclk_y_start} + {1'b0, span};

    // An SOF beat restarts the frame context regardless of the current state
    logic          sof_in, eof_in;
    logic          c_crop, c_active, c_keep, c_first, c_fk, c_hb_vld, is_final;
    logic [LW-1:0] c_start, c_line;
    logic [LW:0]   c_last;
    logic [3:0]    c_scale, c_sub;

    assign sof_in   = aclk_s.tvalid && aclk_s.tuser[0];
    assign eof_in   = aclk_s.tuser[1];
    assign c_crop   = sof_in ? aclk_y_crop_en : crop_q;
    assign c_start  = sof_in ? (aclk_y_crop_en ? aclk_y_start : '0) : start_q;
    assign c_last   = sof_in ? last_in : last_q;
    assign c_scale  = sof_in ? aclk_y_scale : scale_q;
    assign c_line   = sof_in ? '0 : line_q;
    assign c_sub    = sof_in ? '0 : sub_q;
    assign c_active = sof_in || (state_q != ST_IDLE);
    assign c_keep   = sof_in ? (c_start == '0) : (state_q == ST_KEEP);
    assign c_first  = sof_in || first_q;
    assign c_fk     = sof_in || fk_q;
    assign c_hb_vld = !sof_in && hb_vld_q;
    assign is_final = (c_crop && ({1'b0, c_line} == c_last)) || eof_in;

    // Next-line decision taken when a line's tlast is accepted
    logic [LW-1:0] n_line;
    logic [3:0]    n_sub;
    logic          n_keep;

    assign n_line = (c_line == '1) ? c_line : c_line + LW'(1);
    assign n_sub  = (n_line == c_start) ? 4'd0 :
                    (c_sub == c_scale)  ? 4'd0 : c_sub + 4'd1;
    assign n_keep = (n_line >= c_start) && (!c_crop || ({1'b0, n_line} <= c_last)) &&
                    (n_line != '1) && (n_sub == 4'd0);

    assign ob_free = !ob_vld_q || aclk_m.tready;

    logic unused_tuser;
    assign unused_tuser = ^aclk_s.tuser[3:2];

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        sub_d     = sub_q;
        first_d   = first_q;
        fk_d      = fk_q;
        crop_d    = crop_q;
        start_d   = start_q;
        last_d    = last_q;
        scale_d   = scale_q;
        err_d     = err_q;
        hb_vld_d  = hb_vld_q;
        hb_data_d = hb_data_q;
        hb_user_d = hb_user_q;
        ob_load   = 1'b0;
        ob_data_n = aclk_s.tdata;
        ob_user_n = 4'd0;
        ob_last_n = 1'b0;
        beat_user = 4'd0;
        rdy       = 1'b1;

        if (c_active && c_keep) begin
            // A held line end must leave as EOL before the next kept line starts
            if (aclk_s.tvalid && c_first && c_hb_vld) begin
                rdy = 1'b0;
                if (ob_free) begin
                    ob_load   = 1'b1;
                    ob_data_n = hb_data_q;
                    ob_user_n = hb_user_q | U_EOL;
                    ob_last_n = 1'b1;
                    hb_vld_d  = 1'b0;
                end
            end else begin
                rdy = ob_free;
            end
        end else if (c_active && aclk_s.tvalid && eof_in && c_hb_vld) begin
            rdy = ob_free;
        end

        s_tready = rdy_q && rdy;
        acc      = aclk_s.tvalid && s_tready;

        if (acc && sof_in) begin
            err_d    = (state_q != ST_IDLE);
            crop_d   = c_crop;
            start_d  = c_start;
            last_d   = c_last;
            scale_d  = c_scale;
            line_d   = '0;
            sub_d    = 4'd0;
            state_d  = c_keep ? ST_KEEP : ST_DROP;
            first_d  = 1'b1;
            fk_d     = 1'b1;
            hb_vld_d = 1'b0;
        end

        if (acc && c_active) begin
            if (c_keep) begin
                beat_user = c_first ? (c_fk ? U_SOF : U_SOL) : 4'd0;
                first_d   = 1'b0;
                if (c_first) fk_d = 1'b0;
                if (aclk_s.tlast && is_final) begin
                    ob_load   = 1'b1;
                    ob_user_n = beat_user | U_EOF;
                    ob_last_n = 1'b1;
                    state_d   = ST_IDLE;
                end else if (aclk_s.tlast) begin
                    // Marker of a non-final line end is unknown until what follows arrives
                    hb_vld_d  = 1'b1;
                    hb_data_d = aclk_s.tdata;
                    hb_user_d = beat_user;
                    line_d    = n_line;
                    sub_d     = n_sub;
                    state_d   = n_keep ? ST_KEEP : ST_DROP;
                    first_d   = 1'b1;
                end else begin
                    ob_load   = 1'b1;
                    ob_user_n = beat_user;
                end
            end else if (eof_in) begin
                if (c_hb_vld) begin
                    ob_load   = 1'b1;
                    ob_data_n = hb_data_q;
                    ob_user_n = hb_user_q | U_EOF;
                    ob_last_n = 1'b1;
                    hb_vld_d  = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end else if (aclk_s.tlast) begin
                line_d  = n_line;
                sub_d   = n_sub;
                state_d = n_keep ? ST_KEEP : ST_DROP;
                first_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            sub_q     <= 4'd0;
            first_q   <= 1'b0;
            fk_q      <= 1'b0;
            crop_q    <= 1'b0;
            start_q   <= '0;
            last_q    <= '0;
            scale_q   <= 4'd0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            hb_vld_q  <= 1'b0;
            hb_data_q <= '0;
            hb_user_q <= 4'd0;
            ob_vld_q  <= 1'b0;
            ob_data_q <= '0;
            ob_user_q <= 4'd0;
            ob_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            sub_q     <= sub_d;
            first_q   <= first_d;
            fk_q      <= fk_d;
            crop_q    <= crop_d;
            start_q   <= start_d;
            last_q    <= last_d;
            scale_q   <= scale_d;
            err_q     <= err_d;
            rdy_q     <= 1'b1;
            hb_vld_q  <= hb_vld_d;
            hb_data_q <= hb_data_d;
            hb_user_q <= hb_user_d;
            if (ob_load) begin
                ob_vld_q  <= 1'b1;
                ob_data_q <= ob_data_n;
                ob_user_q <= ob_user_n;
                ob_last_q <= ob_last_n;
            end else if (aclk_m.tready) begin
                ob_vld_q  <= 1'b0;
            end
        end
    end

    assign aclk_s.tready  = s_tready;
    assign aclk_m.tvalid  = ob_vld_q;
    assign aclk_m.tdata   = ob_data_q;
    assign aclk_m.tuser   = ob_user_q;
    assign aclk_m.tlast   = ob_last_q;
    assign aclk_frame_err = err_q;
endmodule

// File: tb/tb_y_trim.sv
// Directed bench for y_trim: table of whole-frame crop/scale cases plus hand
// sequences for SOF injection and reset mid-line.
module tb_y_trim;
    localparam int LW = 13;
    localparam int NB = 16;
    localparam int NL = 8;

    logic          aclk = 1'b0;
    logic          aclk_reset_n = 1'b0;
    logic          crop_en = 1'b0;
    logic [LW-1:0] y_start = '0;
    logic [LW-1:0] y_size = '0;
    logic [3:0]    y_scale = '0;
    logic          frame_err;

    y_trim_if s_if ();
    y_trim_if m_if ();

    y_trim #(.LINE_CNT_W(LW)) dut (
        .aclk           (aclk),
        .aclk_reset_n   (aclk_reset_n),
        .aclk_y_crop_en (crop_en),
        .aclk_y_start   (y_start),
        .aclk_y_size    (y_size),
        .aclk_y_scale   (y_scale),
        .aclk_s         (s_if),
        .aclk_m         (m_if),
        .aclk_frame_err (frame_err)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit bp_en = 1'b0;

    always @(posedge aclk) begin
        #1;
        cyc++;
        m_if.tready = bp_en ? ((cyc % 8) != 0) : 1'b1;
    end

    logic [71:0] obs_q[$];
    logic [71:0] exp_q[$];

    always @(negedge aclk)
        if (aclk_reset_n && m_if.tvalid && m_if.tready)
            obs_q.push_back({3'b0, m_if.tlast, m_if.tuser, m_if.tdata});

    function automatic void chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] bd(input int f, input int l, input int b);
        return {16'(f), 16'(l), 16'(b), 16'hA5C3};
    endfunction

    // Expected output beat of a kept line; nb beats pushed starting at beat 0
    function automatic void exp_line(input int f, input int l, input bit first, input bit lastl, input int nb);
        for (int b = 0; b < nb; b++) begin
            logic [3:0] u;
            u = 4'd0;
            if (b == 0)      u = u | (first ? 4'b0001 : 4'b0100);
            if (b == NB - 1) u = u | (lastl ? 4'b0010 : 4'b1000);
            exp_q.push_back({3'b0, 1'(b == NB - 1), u, bd(f, l, b)});
        end
    endfunction

    task automatic send_beat(input int f, input int l, input int b);
        int  n;
        bit  r;
        logic [3:0] u;
        u = 4'd0;
        if (l == 0 && b == 0)           u[0] = 1'b1;
        if (l == NL - 1 && b == NB - 1) u[1] = 1'b1;
        if (l != 0 && b == 0)           u[2] = 1'b1;
        if (l != NL - 1 && b == NB - 1) u[3] = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = bd(f, l, b);
        s_if.tuser  = u;
        s_if.tlast  = (b == NB - 1);
        n = 0;
        forever begin
            @(negedge aclk);
            r = s_if.tready;
            @(posedge aclk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL s_tready_timeout: frame %0d line %0d beat %0d never accepted", f, l, b);
                break;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_lines(input int f, input int l0, input int l1);
        for (int l = l0; l <= l1; l++)
            for (int b = 0; b < NB; b++) send_beat(f, l, b);
    endtask

    task automatic drain();
        repeat (8) @(posedge aclk);
        #1;
    endtask

    task automatic cmp_frame(input string nm);
        chk({nm, "_count"}, 72'(obs_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        bit       crop;
        int       start;
        int       size;
        int       scale;
        bit       bp;
        bit [7:0] mask;
        bit       err;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b0, 0, 0,  0, 1'b1, 8'hFF, 1'b0};  // pass-through, back-pressure
        vt[1] = '{1'b1, 2, 3,  0, 1'b0, 8'h1C, 1'b0};  // crop lines 2..4
        vt[2] = '{1'b1, 1, 6,  1, 1'b0, 8'h2A, 1'b0};  // crop + scale: 1,3,5
        vt[3] = '{1'b0, 0, 0,  2, 1'b0, 8'h49, 1'b0};  // deferred EOF: 0,3,6
        vt[4] = '{1'b1, 10, 2, 0, 1'b0, 8'h00, 1'b1};  // ROI beyond frame
        vt[5] = '{1'b1, 5, 10, 0, 1'b0, 8'hE0, 1'b0};  // ROI past end, EOF from input
        vt[6] = '{1'b0, 0, 0,  7, 1'b0, 8'h01, 1'b0};  // single kept line, deferred EOF
        vt[7] = '{1'b1, 0, 8,  0, 1'b1, 8'hFF, 1'b0};  // full-frame crop, back-pressure

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_state", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata, s_if.tready, frame_err}, 72'd0);
        aclk_reset_n = 1'b1;
        @(negedge aclk);
        chk("tready_before_first_clk", 72'(s_if.tready), 72'd0);
        @(posedge aclk);
        #1;
        chk("tready_after_first_clk", 72'(s_if.tready), 72'd1);

        for (int v = 0; v < 8; v++) begin
            int lastk;
            bit first;
            crop_en = vt[v].crop;
            y_start = LW'(vt[v].start);
            y_size  = LW'(vt[v].size);
            y_scale = 4'(vt[v].scale);
            bp_en   = vt[v].bp;
            lastk = -1;
            for (int l = 0; l < NL; l++) if (vt[v].mask[l]) lastk = l;
            first = 1'b1;
            for (int l = 0; l < NL; l++)
                if (vt[v].mask[l]) begin
                    exp_line(v + 1, l, first, l == lastk, NB);
                    first = 1'b0;
                end
            send_lines(v + 1, 0, NL - 1);
            drain();
            cmp_frame($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_frame_err", v), 72'(frame_err), 72'(vt[v].err));
        end

        // SOF arrives where line 3 should start: line 2's held end is discarded
        crop_en = 1'b0;
        y_scale = 4'd0;
        bp_en   = 1'b0;
        exp_line(10, 0, 1'b1, 1'b0, NB);
        exp_line(10, 1, 1'b0, 1'b0, NB);
        exp_line(10, 2, 1'b0, 1'b0, NB - 1);
        for (int l = 0; l < NL; l++) exp_line(11, l, l == 0, l == NL - 1, NB);
        send_lines(10, 0, 2);
        send_lines(11, 0, NL - 1);
        drain();
        cmp_frame("sof_inject");
        chk("sof_inject_frame_err", 72'(frame_err), 72'd1);

        // Reset asserted while beat 7 of line 2 is presented
        send_lines(20, 0, 1);
        for (int b = 0; b < 7; b++) send_beat(20, 2, b);
        s_if.tvalid  = 1'b1;
        s_if.tdata   = bd(20, 2, 7);
        s_if.tuser   = 4'd0;
        s_if.tlast   = 1'b0;
        aclk_reset_n = 1'b0;
        #1;
        chk("reset_mid_line", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata, s_if.tready, frame_err}, 72'd0);
        s_if.tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aclk_reset_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        @(posedge aclk);
        #1;
        for (int l = 0; l < NL; l++) exp_line(21, l, l == 0, l == NL - 1, NB);
        send_lines(21, 0, NL - 1);
        drain();
        cmp_frame("after_reset");
        chk("after_reset_frame_err", 72'(frame_err), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
